// File: rtl/seq_det_sched.sv
// seq_det_sched: arbitrates NREQ requesters onto one serial 0110 detector and returns its hit count.
// Define SEQ_SCHED_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module seq_det_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*WIDTH-1:0]    req_data_i,
  output logic [NREQ-1:0]          grant_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(NREQ)-1:0]  done_id_o,
  output logic [CNTW-1:0]          hit_count_o,
  output logic                     det_clr_o,
  output logic                     det_bit_o,
  input  logic                     det_hit_i
);
  localparam int IDW = $clog2(NREQ);
  localparam int IXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_e;
  state_e           state_q;
  logic [IDW-1:0]   last_q, id_q, win_d;
  logic [WIDTH-1:0] word_q;
  logic [IXW-1:0]   idx_q;
  logic [CNTW-1:0]  cnt_q, cnt_d, hit_q;
  logic [NREQ-1:0]  grant_q;
  logic             busy_q, done_q, det_clr_q, det_bit_q;
`ifndef SEQ_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]   j;
`endif
  always_comb begin
    win_d = '0;
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) if (req_i[k]) win_d = IDW'(k);
`else
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IDW'((int'(last_q) + k) % NREQ);
      if (req_i[j]) win_d = j;
    end
`endif
  end
  assign cnt_d = (det_hit_i && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      last_q    <= IDW'(NREQ - 1);
      id_q      <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      hit_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      det_clr_q <= 1'b0;
      det_bit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req_i) begin
          state_q        <= CLEAR;
          id_q           <= win_d;
          last_q         <= win_d;
          word_q         <= req_data_i[int'(win_d)*WIDTH +: WIDTH];
          grant_q        <= '0;
          grant_q[win_d] <= 1'b1;
          busy_q         <= 1'b1;
          det_clr_q      <= 1'b1;
          det_bit_q      <= 1'b0;
        end
        CLEAR: begin
          state_q   <= SHIFT;
          idx_q     <= IXW'(WIDTH - 1);
          cnt_q     <= '0;
          det_clr_q <= 1'b0;
          det_bit_q <= word_q[WIDTH-1];
        end
        SHIFT: begin
          cnt_q <= cnt_d;
          if (idx_q == '0) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            hit_q     <= cnt_d;
            det_bit_q <= 1'b0;
          end else begin
            idx_q     <= idx_q - 1'b1;
            det_bit_q <= word_q[idx_q - 1'b1];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign done_id_o   = id_q;
  assign hit_count_o = hit_q;
  assign det_clr_o   = det_clr_q;
  assign det_bit_o   = det_bit_q;
endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: drives seq_det_sched with a behavioural 0110 detector and checks jobs against a reference.
module tb_seq_det_sched;
  localparam int NREQ = 4, WIDTH = 8, CNTW = 4, IDW = 2;
  logic                  clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       grant;
  logic                  busy, done, det_clr, det_bit, det_hit;
  logic [IDW-1:0]        done_id;
  logic [CNTW-1:0]       hit_count;
  int checks = 0, errs = 0, last_m = NREQ - 1;
  seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_data_i(req_data),
    .grant_o(grant), .busy_o(busy), .done_o(done), .done_id_o(done_id),
    .hit_count_o(hit_count), .det_clr_o(det_clr), .det_bit_o(det_bit), .det_hit_i(det_hit)
  );
  always #5 clk = ~clk;
  // detector: remembers the last three accepted bits; hit when they plus the current bit spell 0110
  logic [2:0] hist;
  int seen;
  always @(posedge clk or posedge reset) begin
    if (reset || det_clr) begin
      hist <= '0;
      seen <= 0;
    end else begin
      hist <= {hist[1:0], det_bit};
      seen <= (seen < 3) ? seen + 1 : 3;
    end
  end
  assign det_hit = (seen == 3) && ({hist, det_bit} == 4'b0110);
  function automatic int hits_of(logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = WIDTH - 1; i >= 3; i--) if (w[i -: 4] == 4'b0110) n++;
    return (n > (1 << CNTW) - 1) ? (1 << CNTW) - 1 : n;
  endfunction
  function automatic int pick(logic [NREQ-1:0] r, int last);
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // req must already be driven; the task returns at the first IDLE negedge after the job
  task automatic run_job(logic [NREQ-1:0] exp_grant, int id, int hits, int mid, bit drop);
    int n = 0;
    @(negedge clk);
    chk("grant", int'(grant), int'(exp_grant));
    chk("busy_at_grant", int'(busy), 1);
    chk("det_clr_pulse", int'(det_clr), 1);
    while (!done && n < 3 * WIDTH) begin
      @(negedge clk);
      n++;
      if (n == mid) begin
        req_data = {$urandom};
        if (drop) req[id] = 1'b0;
      end
      if (!done) chk("det_clr_in_shift", int'(det_clr), 0);
    end
    chk("done_latency", n, WIDTH + 1);
    chk("done_id", int'(done_id), id);
    chk("hit_count", int'(hit_count), hits);
    chk("grant_held_in_done", int'(grant), int'(exp_grant));
    req[id] = 1'b0;
    last_m = id;
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("grant_released", int'(grant), 0);
    chk("busy_released", int'(busy), 0);
    chk("hit_count_held", int'(hit_count), hits);
  endtask
  task automatic chk_zero(string nm);
    chk({nm, "_grant"}, int'(grant), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_done_id"}, int'(done_id), 0);
    chk({nm, "_hit_count"}, int'(hit_count), 0);
    chk({nm, "_det_clr"}, int'(det_clr), 0);
    chk({nm, "_det_bit"}, int'(det_bit), 0);
  endtask
  typedef struct {
    int              id;
    logic [WIDTH-1:0] word;
    logic [NREQ-1:0]  grant;
    int              hits;
  } vec_t;
  vec_t vecs[8];
  initial begin
    int id;
    vecs[0] = '{0, 8'b0110_0110, 4'b0001, 2};
    vecs[1] = '{2, 8'b0110_1100, 4'b0100, 2};
    vecs[2] = '{2, 8'hFF,        4'b0100, 0};
    vecs[3] = '{2, 8'h00,        4'b0100, 0};
    vecs[4] = '{3, 8'b0000_0011, 4'b1000, 0};
    vecs[5] = '{3, 8'b0000_0110, 4'b1000, 1};
    vecs[6] = '{1, 8'b0110_1101, 4'b0010, 2};
    vecs[7] = '{0, 8'b0011_0110, 4'b0001, 2};
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    foreach (vecs[i]) begin
      req_data = {$urandom};
      req_data[vecs[i].id*WIDTH +: WIDTH] = vecs[i].word;
      req[vecs[i].id] = 1'b1;
      run_job(vecs[i].grant, vecs[i].id, vecs[i].hits, 0, 1'b0);
    end
    // all four held from reset: served 0,1,2,3
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_m = NREQ - 1;
    req = '1;
    req_data = {$urandom};
    for (int k = 0; k < NREQ; k++) begin
      id = pick(req, last_m);
      chk("all_req_order", id, k);
      run_job(NREQ'(1) << id, id, hits_of(req_data[id*WIDTH +: WIDTH]), 0, 1'b0);
    end
    // word latched at grant: data scrambled and req dropped mid-shift
    req_data = {$urandom};
    req_data[1*WIDTH +: WIDTH] = 8'b0110_0110;
    req[1] = 1'b1;
    run_job(4'b0010, 1, 2, 3, 1'b1);
    // reset during shift aborts the job without a done
    req_data = {$urandom};
    req[2] = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("abort");
    req = '0;
    repeat (2) begin
      @(negedge clk);
      chk("no_done_after_abort", int'(done), 0);
    end
    reset = 1'b0;
    last_m = NREQ - 1;
    req_data[3*WIDTH +: WIDTH] = 8'b0110_1100;
    req[3] = 1'b1;
    run_job(4'b1000, 3, 2, 0, 1'b0);
    // random contention against the reference arbiter and hit counter
    repeat (40) begin
      req |= NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) req &= NREQ'($urandom);
      if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
      req_data = {$urandom};
      id = pick(req, last_m);
      run_job(NREQ'(1) << id, id, hits_of(req_data[id*WIDTH +: WIDTH]),
              int'($urandom_range(0, WIDTH)), 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end
endmodule
